// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among N_REQ byte-stream requesters.
// The owner keeps the grant until its last byte, MAX_BURST bytes, or a HOLD_TO-cycle stall.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned HOLD_TO   = 64,
  parameter int unsigned BUSY_TO   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic                       grant_vld,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned HW = $clog2(HOLD_TO + 1);
  localparam int unsigned TW = $clog2(BUSY_TO + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] busy_cnt;
  logic          last_q;

  logic [IW-1:0] win_c;
  logic [IW-1:0] sel_id_c;
  logic [7:0]    sel_byte_c;
  logic          sel_last_c;
  logic          grant_ok_c;
  logic          frame_end_c;
  logic          byte_done_c;
  logic          hold_to_c;
  logic          release_c;

  // Winner is the valid requester at the smallest rotational distance from rr_ptr.
  always_comb begin
    int unsigned d;
    int unsigned best;
    d     = 0;
    best  = N_REQ;
    win_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      d = (i >= 32'(rr_ptr)) ? i - 32'(rr_ptr) : i + N_REQ - 32'(rr_ptr);
      if (req_valid[i] && d < best) begin
        best  = d;
        win_c = IW'(i);
      end
    end
  end

  always_comb begin
    sel_id_c   = (state == HOLD) ? grant_id : win_c;
    sel_byte_c = '0;
    sel_last_c = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IW'(i) == sel_id_c) begin
        sel_byte_c = req_data[8*i +: 8];
        sel_last_c = req_last[i];
      end
    end
  end

  // Ready is combinational so the accepting edge is the same cycle the grant is decided.
  always_comb begin
    grant_ok_c = ena && (|req_valid) && !tx_busy;
    req_ready  = '0;
    if (rst_n) begin
      if (state == IDLE && grant_ok_c) req_ready[win_c]    = 1'b1;
      if (state == HOLD)               req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    frame_end_c = last_q || (burst_cnt == BW'(MAX_BURST));
    byte_done_c = ((state == WAIT_BUSY) && !tx_busy && (busy_cnt == TW'(BUSY_TO - 1))) ||
                  ((state == WAIT_DONE) && !tx_busy);
    hold_to_c   = (state == HOLD) && !req_valid[grant_id] && (hold_cnt == HW'(HOLD_TO - 1));
    release_c   = (byte_done_c && frame_end_c) || hold_to_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      hold_cnt  <= '0;
      busy_cnt  <= '0;
      last_q    <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      grant_vld <= 1'b0;
      grant_id  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok_c) begin
            tx_data   <= sel_byte_c;
            last_q    <= sel_last_c;
            grant_id  <= win_c;
            grant_vld <= 1'b1;
            burst_cnt <= BW'(1);
            tx_start  <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy)           state    <= WAIT_DONE;
          else if (!byte_done_c) busy_cnt <= busy_cnt + TW'(1);
        end
        WAIT_DONE: ;
        HOLD: begin
          if (req_valid[grant_id]) begin
            tx_data   <= sel_byte_c;
            last_q    <= sel_last_c;
            burst_cnt <= burst_cnt + BW'(1);
            tx_start  <= 1'b1;
            state     <= START;
          end else if (!hold_to_c) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // Byte finished mid-frame: wait in HOLD for the owner's next byte.
      if (byte_done_c && !frame_end_c) begin
        hold_cnt <= '0;
        state    <= HOLD;
      end
      if (release_c) begin
        grant_vld <= 1'b0;
        rr_ptr    <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, a TX core model and a tx_start log.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int BUSY_LEN = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_ready;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             grant_vld;
  logic [1:0]       grant_id;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(16), .HOLD_TO(64), .BUSY_TO(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant_vld(grant_vld), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // TX core model: busy for BUSY_LEN cycles after each start pulse.
  int   bcnt = 0;
  logic model_en = 1'b1;
  logic ext_busy = 1'b0;
  assign tx_busy = (bcnt != 0) || ext_busy;
  always @(posedge clk) begin
    if (model_en && tx_start) bcnt <= BUSY_LEN;
    else if (bcnt != 0)       bcnt <= bcnt - 1;
  end

  // Byte sources: {last, data}; tasks append, the pop process advances.
  logic [8:0] src_mem [N][64];
  int         src_len [N] = '{default: 0};
  int         src_pos [N] = '{default: 0};

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
        req_last[i]        = src_mem[i][src_pos[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) src_pos[i] <= src_pos[i] + 1;
  end

  // Log of every start pulse and count of grant releases.
  logic [7:0] log_data [256];
  logic [1:0] log_id   [256];
  int         log_n = 0;
  int         rel_cnt = 0;
  logic       prev_gv = 1'b0;
  always @(posedge clk) begin
    if (tx_start && log_n < 256) begin
      log_data[log_n] <= tx_data;
      log_id[log_n]   <= grant_id;
      log_n           <= log_n + 1;
    end
    prev_gv <= grant_vld;
    if (prev_gv && !grant_vld) rel_cnt <= rel_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic last);
    src_mem[r][src_len[r]] = {last, d};
    src_len[r] = src_len[r] + 1;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++)
      if (src_pos[i] < src_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int maxc, input string name);
    int n;
    n = 0;
    tick();
    while (!(drained() && !grant_vld && !tx_busy) && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_idle: still active after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks += 5;
    if (tx_start !== 1'b0)  begin errors++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
    if (tx_data !== 8'h00)  begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    if (grant_vld !== 1'b0) begin errors++; $display("FAIL rst_grant_vld: got %b want 0", grant_vld); end
    if (grant_id !== 2'd0)  begin errors++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    if (req_ready !== 4'h0) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (grant_vld !== 1'b0) begin errors++; $display("FAIL post_rst_grant: got %b want 0", grant_vld); end
  endtask

  task automatic test_single_frame();
    int b, n;
    logic [7:0] exp_d [3];
    exp_d = '{8'h41, 8'h42, 8'h43};
    b = log_n;
    load(0, 8'h41, 1'b0); load(0, 8'h42, 1'b0); load(0, 8'h43, 1'b1);
    n = 0;
    tick();
    while (!req_ready[0] && n < 20) begin tick(); n++; end
    checks += 5;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL frame_ready: got %b want 0001", req_ready); end
    tick();
    if (tx_start !== 1'b1)  begin errors++; $display("FAIL frame_start_lat: got %b want 1", tx_start); end
    if (tx_data !== 8'h41)  begin errors++; $display("FAIL frame_first_data: got %h want 41", tx_data); end
    if (grant_vld !== 1'b1 || grant_id !== 2'd0) begin
      errors++; $display("FAIL frame_grant: got vld=%b id=%0d want vld=1 id=0", grant_vld, grant_id);
    end
    tick();
    if (tx_start !== 1'b0)  begin errors++; $display("FAIL frame_pulse_width: got %b want 0", tx_start); end
    wait_idle(300, "frame");
    checks++;
    if (log_n - b !== 3) begin errors++; $display("FAIL frame_count: got %0d want 3", log_n - b); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (log_data[b+k] !== exp_d[k] || log_id[b+k] !== 2'd0) begin
        errors++;
        $display("FAIL frame_byte%0d: got id=%0d data=%h want id=0 data=%h", k, log_id[b+k], log_data[b+k], exp_d[k]);
      end
    end
  endtask

  task automatic test_rotation();
    int b;
    logic [1:0] exp_id [4];
    logic [7:0] exp_d [4];
    exp_id = '{2'd1, 2'd3, 2'd0, 2'd1};
    exp_d  = '{8'h51, 8'h53, 8'h60, 8'h61};
    b = log_n;
    load(1, 8'h51, 1'b1); load(3, 8'h53, 1'b1);
    wait_idle(200, "rot_a");
    // After the req3 release the pointer wraps to 0, so req0 beats req1.
    load(0, 8'h60, 1'b1); load(1, 8'h61, 1'b1);
    wait_idle(200, "rot_b");
    checks++;
    if (log_n - b !== 4) begin errors++; $display("FAIL rot_count: got %0d want 4", log_n - b); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_id[b+k] !== exp_id[k] || log_data[b+k] !== exp_d[k]) begin
        errors++;
        $display("FAIL rot_grant%0d: got id=%0d data=%h want id=%0d data=%h",
                 k, log_id[b+k], log_data[b+k], exp_id[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_burst();
    int b, r0, n;
    logic [1:0] ei;
    logic [7:0] ed;
    b = log_n;
    r0 = rel_cnt;
    for (int i = 0; i < 17; i++) load(2, 8'(i), 1'b0);
    wait_idle(1000, "burst_alone");
    checks += 2;
    if (log_n - b !== 17) begin errors++; $display("FAIL burst_alone_count: got %0d want 17", log_n - b); end
    if (rel_cnt - r0 !== 2) begin errors++; $display("FAIL burst_alone_releases: got %0d want 2", rel_cnt - r0); end
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (log_id[b+k] !== 2'd2 || log_data[b+k] !== 8'(k)) begin
        errors++; $display("FAIL burst_alone%0d: got id=%0d data=%h want id=2 data=%h", k, log_id[b+k], log_data[b+k], 8'(k));
      end
    end
    b = log_n;
    for (int i = 0; i < 20; i++) load(2, 8'(8'h80 + i), 1'b0);
    n = 0;
    tick();
    while (!(grant_vld && grant_id == 2'd2) && n < 20) begin tick(); n++; end
    load(0, 8'hAA, 1'b1);
    wait_idle(1200, "burst_shared");
    checks++;
    if (log_n - b !== 21) begin errors++; $display("FAIL burst_shared_count: got %0d want 21", log_n - b); end
    for (int k = 0; k < 21; k++) begin
      if (k < 16)       begin ei = 2'd2; ed = 8'(8'h80 + k);     end
      else if (k == 16) begin ei = 2'd0; ed = 8'hAA;             end
      else              begin ei = 2'd2; ed = 8'(8'h80 + k - 1); end
      checks++;
      if (log_id[b+k] !== ei || log_data[b+k] !== ed) begin
        errors++; $display("FAIL burst_shared%0d: got id=%0d data=%h want id=%0d data=%h", k, log_id[b+k], log_data[b+k], ei, ed);
      end
    end
  endtask

  task automatic test_hold_timeout();
    int b, n, idle;
    b = log_n;
    load(3, 8'h31, 1'b0); load(3, 8'h32, 1'b0);
    n = 0;
    tick();
    while (!(grant_vld && grant_id == 2'd3) && n < 20) begin tick(); n++; end
    load(1, 8'h5A, 1'b1);
    n = 0;
    while (log_n < b + 2 && n < 100) begin tick(); n++; end
    idle = 0;
    n = 0;
    while (grant_vld && n < 300) begin
      if (!tx_busy && !tx_start) idle++;
      if (idle == 10) begin
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL hold_ready_owner_only: got %b want 1000", req_ready); end
      end
      tick();
      n++;
    end
    // One WAIT_DONE cycle with busy low plus HOLD_TO=64 stalled cycles.
    checks += 6;
    if (idle !== 65) begin errors++; $display("FAIL hold_idle_cycles: got %0d want 65", idle); end
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_next_ready: got %b want 0010", req_ready); end
    tick();
    if (grant_vld !== 1'b1) begin errors++; $display("FAIL hold_next_vld: got %b want 1", grant_vld); end
    if (grant_id !== 2'd1)  begin errors++; $display("FAIL hold_next_id: got %0d want 1", grant_id); end
    if (tx_start !== 1'b1)  begin errors++; $display("FAIL hold_next_start: got %b want 1", tx_start); end
    if (tx_data !== 8'h5A)  begin errors++; $display("FAIL hold_next_data: got %h want 5a", tx_data); end
    wait_idle(300, "hold");
  endtask

  task automatic test_ena();
    int b, n;
    logic [1:0] exp_id [6];
    logic [7:0] exp_d [6];
    exp_id = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_d  = '{8'hC0, 8'hC1, 8'hC2, 8'hD3, 8'hE0, 8'hE1};
    ena = 1'b0;
    b = log_n;
    load(0, 8'hE0, 1'b1); load(1, 8'hE1, 1'b1); load(3, 8'hD3, 1'b1);
    load(2, 8'hC0, 1'b0); load(2, 8'hC1, 1'b0); load(2, 8'hC2, 1'b1);
    repeat (30) tick();
    checks += 3;
    if (log_n !== b)        begin errors++; $display("FAIL ena_off_starts: got %0d want 0", log_n - b); end
    if (grant_vld !== 1'b0) begin errors++; $display("FAIL ena_off_grant: got %b want 0", grant_vld); end
    if (req_ready !== 4'h0) begin errors++; $display("FAIL ena_off_ready: got %b want 0000", req_ready); end
    ena = 1'b1;
    n = 0;
    while (log_n < b + 1 && n < 20) begin tick(); n++; end
    ena = 1'b0;
    repeat (80) tick();
    checks += 2;
    if (log_n - b !== 3)    begin errors++; $display("FAIL ena_frame_done: got %0d starts want 3", log_n - b); end
    if (grant_vld !== 1'b0) begin errors++; $display("FAIL ena_no_regrant: got %b want 0", grant_vld); end
    ena = 1'b1;
    wait_idle(300, "ena");
    checks++;
    if (log_n - b !== 6) begin errors++; $display("FAIL ena_total: got %0d want 6", log_n - b); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (log_id[b+k] !== exp_id[k] || log_data[b+k] !== exp_d[k]) begin
        errors++; $display("FAIL ena_grant%0d: got id=%0d data=%h want id=%0d data=%h",
                           k, log_id[b+k], log_data[b+k], exp_id[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_idle_busy();
    int b;
    ext_busy = 1'b1;
    b = log_n;
    load(0, 8'h77, 1'b1);
    repeat (10) tick();
    checks += 2;
    if (grant_vld !== 1'b0 || log_n !== b) begin
      errors++; $display("FAIL busy_idle_grant: got vld=%b starts=%0d want vld=0 starts=0", grant_vld, log_n - b);
    end
    if (req_ready !== 4'h0) begin errors++; $display("FAIL busy_idle_ready: got %b want 0000", req_ready); end
    ext_busy = 1'b0;
    wait_idle(100, "busy_idle");
    checks++;
    if (log_n - b !== 1 || log_id[b] !== 2'd0 || log_data[b] !== 8'h77) begin
      errors++; $display("FAIL busy_idle_after: got n=%0d id=%0d data=%h want n=1 id=0 data=77", log_n - b, log_id[b], log_data[b]);
    end
  endtask

  task automatic test_busy_timeout();
    int b, n;
    model_en = 1'b0;
    b = log_n;
    load(1, 8'h99, 1'b1);
    n = 0;
    tick();
    while (!tx_start && n < 20) begin tick(); n++; end
    n = 0;
    tick();
    while (grant_vld && n < 20) begin n++; tick(); end
    checks += 2;
    if (n !== 4) begin errors++; $display("FAIL busy_to_cycles: got %0d want 4", n); end
    if (log_n - b !== 1 || log_id[b] !== 2'd1 || log_data[b] !== 8'h99) begin
      errors++; $display("FAIL busy_to_byte: got n=%0d id=%0d data=%h want n=1 id=1 data=99", log_n - b, log_id[b], log_data[b]);
    end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int b, n;
    b = log_n;
    load(2, 8'h31, 1'b0); load(2, 8'h32, 1'b0); load(2, 8'h33, 1'b1);
    n = 0;
    tick();
    while (!(grant_vld && tx_busy && !tx_start) && n < 30) begin tick(); n++; end
    tick();
    checks += 6;
    if (tx_data !== 8'h31 || grant_id !== 2'd2) begin
      errors++; $display("FAIL mid_pre_state: got id=%0d data=%h want id=2 data=31", grant_id, tx_data);
    end
    #2 rst_n = 1'b0;
    #1;
    if (tx_start !== 1'b0)  begin errors++; $display("FAIL mid_rst_start: got %b want 0", tx_start); end
    if (tx_data !== 8'h00)  begin errors++; $display("FAIL mid_rst_data: got %h want 00", tx_data); end
    if (grant_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld: got %b want 0", grant_vld); end
    if (grant_id !== 2'd0)  begin errors++; $display("FAIL mid_rst_id: got %0d want 0", grant_id); end
    if (req_ready !== 4'h0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    wait_idle(300, "mid_rst");
    checks++;
    if (log_n - b !== 3 || log_data[b+1] !== 8'h32 || log_data[b+2] !== 8'h33) begin
      errors++; $display("FAIL mid_rst_resume: got n=%0d d1=%h d2=%h want n=3 d1=32 d2=33",
                         log_n - b, log_data[b+1], log_data[b+2]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_rotation();
    test_burst();
    test_hold_timeout();
    test_ena();
    test_idle_busy();
    test_busy_timeout();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
